serial_subtractor: RTL and testbench

Multi-cycle bit-serial subtractor, the inverse datapath of the ripple-carry adder in the arithmetic library. A single full-subtractor cell is reused one bit per clock, LSB first. It computes diff = A - B - bin (mod 2^WIDTH) and a borrow-out. Start/busy/done handshake lets a testbench or controller launch an operation and collect the result.

---
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB first, diff = a - b - bin.
// Define SERIAL_SUB_OVF_EN to add a registered two's-complement overflow output (ovf).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             d_bit;
    logic             br_nx;
    logic [WIDTH-1:0] res_sh;
`ifdef SERIAL_SUB_OVF_EN
    logic             am_q, am_d;
    logic             bm_q, bm_d;
    logic             ovf_q, ovf_d;
`endif

    assign d_bit  = x_q[0] ^ y_q[0] ^ br_q;
    assign br_nx  = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & br_q);
    assign res_sh = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        am_d    = am_q;
        bm_d    = bm_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = a;
                    y_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                res_d = res_sh;
                br_d  = br_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Last bit: publish the result as DONE is entered.
                    state_d = DONE;
                    diff_d  = res_sh;
                    bout_d  = br_nx;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (am_q != bm_q) && (res_sh[WIDTH-1] != am_q);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            am_q    <= am_d;
            bm_q    <= bm_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=4).
// Expected values are hand-computed or derived from plain integer subtraction.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int tests;
    int fails;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, output int lat, output int nbusy,
                         output logic [W-1:0] d, output logic bo);
        @(negedge clk);
        a = xa;
        b = xb;
        bin = xc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) nbusy++;
        d = diff;
        bo = bout;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, diff, bout} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%0d bout=%b, want all 0",
                     busy, done, diff, bout);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [W-1:0] va [5] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd15};
        logic [W-1:0] vb [5] = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd0};
        logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] ed [5] = '{4'd6, 4'd10, 4'd15, 4'd15, 4'd15};
        logic         eb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int lat, nb;
        logic [W-1:0] d;
        logic bo;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], lat, nb, d, bo);
            tests++;
            if (lat !== W + 1) begin
                fails++;
                $display("FAIL basic_latency[%0d]: got %0d, want %0d", i, lat, W + 1);
            end
            tests++;
            if (nb !== W + 1) begin
                fails++;
                $display("FAIL basic_busy_cycles[%0d]: got %0d, want %0d", i, nb, W + 1);
            end
            tests++;
            if ({bo, d} !== {eb[i], ed[i]}) begin
                fails++;
                $display("FAIL basic_result[%0d]: got diff=%0d bout=%b, want diff=%0d bout=%b",
                         i, d, bo, ed[i], eb[i]);
            end
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd15 || bout !== 1'b0) begin
            fails++;
            $display("FAIL hold_after_done: got busy=%b done=%b diff=%0d bout=%b, want 0 0 15 0",
                     busy, done, diff, bout);
        end
    endtask

    task automatic test_busy_ignore;
        int ndone;
        logic [W-1:0] d;
        logic bo;
        int lat, nb;
        ndone = 0;
        d = '0;
        @(negedge clk);
        a = 4'd5;
        b = 4'd2;
        bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'd1;
        b = 4'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (done === 1'b1) begin
                ndone++;
                d = diff;
            end
            @(negedge clk);
        end
        tests++;
        if (ndone !== 1) begin
            fails++;
            $display("FAIL ignore_done_count: got %0d, want 1", ndone);
        end
        tests++;
        if (d !== 4'd3) begin
            fails++;
            $display("FAIL ignore_result: got diff=%0d, want 3", d);
        end
        do_op(4'd1, 4'd1, 1'b0, lat, nb, d, bo);
        tests++;
        if ({bo, d} !== 5'd0 || lat !== W + 1) begin
            fails++;
            $display("FAIL after_ignore: got diff=%0d bout=%b lat=%0d, want 0 0 %0d",
                     d, bo, lat, W + 1);
        end
    endtask

    task automatic test_reset_mid;
        int lat, nb, ndone;
        logic [W-1:0] d;
        logic bo;
        do_op(4'd3, 4'd9, 1'b0, lat, nb, d, bo);
        @(negedge clk);
        a = 4'd12;
        b = 4'd4;
        bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, diff, bout} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b diff=%0d bout=%b, want all 0",
                     busy, done, diff, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        tests++;
        if (ndone !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: got %0d pulses, want 0", ndone);
        end
        do_op(4'd12, 4'd4, 1'b0, lat, nb, d, bo);
        tests++;
        if ({bo, d} !== {1'b0, 4'd8}) begin
            fails++;
            $display("FAIL after_reset: got diff=%0d bout=%b, want 8 0", d, bo);
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2, seen;
        t1 = -1;
        t2 = -1;
        seen = 0;
        @(negedge clk);
        a = 4'd9;
        b = 4'd3;
        bin = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 40 && seen < 2; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (seen == 0) t1 = k;
                else t2 = k;
                seen++;
            end
        end
        start = 1'b0;
        tests++;
        if (seen !== 2 || (t2 - t1) !== W + 2) begin
            fails++;
            $display("FAIL back_to_back_period: got %0d (pulses %0d), want %0d",
                     t2 - t1, seen, W + 2);
        end
        tests++;
        if (diff !== 4'd6) begin
            fails++;
            $display("FAIL back_to_back_result: got %0d, want 6", diff);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back_idle: got busy=%b, want 0", busy);
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int lat, nb;
        logic [W-1:0] d;
        logic bo;
        do_op(4'd8, 4'd1, 1'b0, lat, nb, d, bo);
        tests++;
        if (d !== 4'd7 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: got diff=%0d ovf=%b, want 7 1", d, ovf);
        end
        do_op(4'd7, 4'd1, 1'b0, lat, nb, d, bo);
        tests++;
        if (d !== 4'd6 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got diff=%0d ovf=%b, want 6 0", d, ovf);
        end
    endtask
`endif

    task automatic test_random;
        int lat, nb;
        logic [W-1:0] d, xa, xb;
        logic bo, xc;
        logic [W:0] exp;
        for (int i = 0; i < 200; i++) begin
            xa = W'($urandom_range(0, (1 << W) - 1));
            xb = W'($urandom_range(0, (1 << W) - 1));
            xc = 1'($urandom_range(0, 1));
            exp = {1'b0, xa} - {1'b0, xb} - {{W{1'b0}}, xc};
            do_op(xa, xb, xc, lat, nb, d, bo);
            tests++;
            if ({bo, d} !== exp || lat !== W + 1) begin
                fails++;
                $display("FAIL random[%0d] %0d-%0d-%0d: got diff=%0d bout=%b lat=%0d, want %0d %b %0d",
                         i, xa, xb, xc, d, bo, lat, exp[W-1:0], exp[W], W + 1);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
